// File: rtl/sig_pattern_detector.sv
// sig_pattern_detector
// Receive-side decoder for the 12-slot serial marker line. The line is
// synchronised, slot timing is recovered from line edges, each slot is sampled
// at mid-slot, and the frame pattern is searched for and then tracked slot by
// slot. Lock state, completed frames and slot errors are reported on
// registered outputs.
module sig_pattern_detector #(
  parameter int          SLOT_CLKS = 5000000,
  parameter logic [11:0] PATTERN   = 12'b110011001000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSIG,
  output logic       oLOCK,
  output logic       oMATCH,
  output logic       oERR,
  output logic [3:0] oSLOT,
  output logic [7:0] oFRAMES
);

  localparam int            PW      = $clog2(SLOT_CLKS);
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CLKS - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(SLOT_CLKS / 2);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Synchroniser and edge-detect flops
  logic s1_q, s2_q, s3_q;
  logic edge_det;

  // Slot phase recovery
  logic [PW-1:0] phase_q, phase_d;
  logic          strobe;

  // Sample history and frame tracking
  logic [11:0] shreg_q, shreg_d;
  logic [3:0]  fill_q, fill_d;
  state_t      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [7:0]  frames_q, frames_d;
  logic        match_q, match_d;
  logic        err_q, err_d;
  logic [3:0]  pat_idx;

  // Two-flop synchroniser on the asynchronous line plus a third flop for edges
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= iSIG;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q ^ s3_q;

  // An edge takes priority over the mid-slot sample, so a coincident edge
  // re-phases without sampling.
  assign strobe = (phase_q == PH_MID) && !edge_det;

  // Free-running slot phase, re-zeroed on every line edge
  always_comb begin
    phase_d = phase_q + 1'b1;
    if (edge_det || (phase_q == PH_LAST)) begin
      phase_d = '0;
    end
  end

  // Frame search / tracking: shift in samples, hunt for the pattern, then
  // check each slot against the expected bit while locked
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    fill_d   = fill_q;
    slot_d   = slot_q;
    frames_d = frames_q;
    match_d  = 1'b0;
    err_d    = 1'b0;
    pat_idx  = 4'd11 - slot_q;
    if (strobe) begin
      shreg_d = {shreg_q[10:0], s2_q};
      if (fill_q != 4'd12) begin
        fill_d = fill_q + 4'd1;
      end
      case (state_q)
        HUNT: begin
          if ((fill_d == 4'd12) && (shreg_d == PATTERN)) begin
            state_d  = LOCKED;
            match_d  = 1'b1;
            frames_d = frames_q + 8'd1;
            slot_d   = 4'd0;
          end
        end
        LOCKED: begin
          if (s2_q == PATTERN[pat_idx]) begin
            if (slot_q == 4'd11) begin
              slot_d   = 4'd0;
              match_d  = 1'b1;
              frames_d = frames_q + 8'd1;
            end else begin
              slot_d = slot_q + 4'd1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            fill_d  = 4'd0;
            slot_d  = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // State, phase and frame-tracking registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      phase_q  <= '0;
      shreg_q  <= '0;
      fill_q   <= 4'd0;
      state_q  <= HUNT;
      slot_q   <= 4'd0;
      frames_q <= 8'd0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      slot_q   <= slot_d;
      frames_q <= frames_d;
      match_q  <= match_d;
      err_q    <= err_d;
    end
  end

  assign oLOCK   = (state_q == LOCKED);
  assign oMATCH  = match_q;
  assign oERR    = err_q;
  assign oSLOT   = slot_q;
  assign oFRAMES = frames_q;

endmodule

// File: tb/tb_sig_pattern_detector.sv
// Testbench for sig_pattern_detector with SLOT_CLKS = 8. Stimulus tasks push
// the expected oMATCH/oERR events into a scoreboard queue; a negedge monitor
// pops and compares whenever the DUT pulses either output.
module tb_sig_pattern_detector;

  localparam int          SC  = 8;
  localparam logic [11:0] PAT = 12'b110011001000;
  localparam int          K_MATCH = 1;
  localparam int          K_ERR   = 2;

  logic       iCLK;
  logic       iRST;
  logic       iSIG;
  logic       oLOCK;
  logic       oMATCH;
  logic       oERR;
  logic [3:0] oSLOT;
  logic [7:0] oFRAMES;

  typedef struct {
    int kind;
    int cyc;
    int frames;
    int lock;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  sig_pattern_detector #(
    .SLOT_CLKS(SC),
    .PATTERN  (PAT)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSIG   (iSIG),
    .oLOCK  (oLOCK),
    .oMATCH (oMATCH),
    .oERR   (oERR),
    .oSLOT  (oSLOT),
    .oFRAMES(oFRAMES)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  // Monitor: every pulse must correspond to the next expected event
  always @(negedge iCLK) begin
    if (oMATCH && oERR) chk("match_and_err_together", 1, 0);
    if (oMATCH || oERR) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", oMATCH ? K_MATCH : K_ERR, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", oMATCH ? K_MATCH : K_ERR, mon_e.kind);
        if (mon_e.cyc >= 0) chk("event_cycle", cyc, mon_e.cyc);
        chk("event_frames", int'(oFRAMES), mon_e.frames);
        chk("event_lock", int'(oLOCK), mon_e.lock);
        chk("event_slot", int'(oSLOT), 0);
      end
    end
  end

  // Entered and left at #1 after a rising edge. With unjittered slots the
  // sample of a slot shows up on the outputs 8 edges after the slot starts.
  task automatic send_slot(input logic b, input int dur, input int kind,
                           input int fr, input int lk, input bit timed);
    ev_t e;
    iSIG = b;
    if (kind != 0) begin
      e.kind   = kind;
      e.cyc    = timed ? cyc + SC : -1;
      e.frames = fr;
      e.lock   = lk;
      sb.push_back(e);
    end
    repeat (dur) @(posedge iCLK);
    #1;
  endtask

  task automatic send_frame(input logic [11:0] f, input int fr);
    for (int i = 0; i < 12; i++) begin
      send_slot(f[11-i], SC, (i == 11) ? K_MATCH : 0, fr, 1, 1'b1);
    end
  endtask

  task automatic do_reset();
    repeat (3) @(posedge iCLK);
    #1;
    iSIG = 1'b0;
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    repeat (10) @(posedge iCLK);
    #1;
  endtask

  initial begin
    logic [11:0] bad;
    logic        bits[36];
    int          d[37];
    int          r;

    iRST = 1'b1;
    iSIG = 1'b0;
    @(posedge iCLK);
    #1;

    // Reset held with the line toggling
    for (int i = 0; i < 3; i++) begin
      iSIG = ~iSIG;
      @(posedge iCLK);
      #1;
      chk("rst_lock", int'(oLOCK), 0);
      chk("rst_match", int'(oMATCH), 0);
      chk("rst_err", int'(oERR), 0);
      chk("rst_slot", int'(oSLOT), 0);
      chk("rst_frames", int'(oFRAMES), 0);
    end
    iRST = 1'b0;
    iSIG = 1'b0;
    repeat (10) @(posedge iCLK);
    #1;

    // Lock and count over two back-to-back frames
    send_frame(PAT, 1);
    chk("lock_after_f1", int'(oLOCK), 1);
    chk("frames_after_f1", int'(oFRAMES), 1);
    send_frame(PAT, 2);
    chk("lock_after_f2", int'(oLOCK), 1);
    chk("frames_after_f2", int'(oFRAMES), 2);
    do_reset();

    // Corrupted slot 9, then recovery on the next full frame
    send_frame(PAT, 1);
    bad = PAT | 12'b000000000100;
    for (int i = 0; i < 12; i++) begin
      send_slot(bad[11-i], SC, (i == 9) ? K_ERR : 0, 1, 0, 1'b1);
      if (i == 9) begin
        chk("err_lock_dropped", int'(oLOCK), 0);
        chk("err_frames_held", int'(oFRAMES), 1);
      end
    end
    send_frame(PAT, 2);
    chk("relock_after_err", int'(oLOCK), 1);
    do_reset();

    // Constant lines
    iSIG = 1'b0;
    repeat (200) @(posedge iCLK);
    #1;
    iSIG = 1'b1;
    repeat (200) @(posedge iCLK);
    #1;
    chk("const_lock", int'(oLOCK), 0);
    chk("const_frames", int'(oFRAMES), 0);
    do_reset();

    // Jitter: edge boundaries shifted by -2/0/+2 cycles
    for (int i = 0; i < 36; i++) bits[i] = PAT[11 - (i % 12)];
    d[0] = 0;
    for (int i = 1; i < 36; i++) begin
      if (bits[i] != bits[i-1]) begin
        r = int'($urandom_range(2, 0)) * 2 - 2;
        if (r < d[i-1] - 2) r = d[i-1] - 2;
        d[i] = r;
      end else begin
        d[i] = d[i-1];
      end
    end
    d[36] = 0;
    for (int i = 0; i < 36; i++) begin
      send_slot(bits[i], SC + d[i+1] - d[i], ((i % 12) == 11) ? K_MATCH : 0,
                (i / 12) + 1, 1, 1'b0);
    end
    repeat (4) @(posedge iCLK);
    #1;
    chk("jitter_frames", int'(oFRAMES), 3);
    do_reset();

    // Reset while locked at slot 5, then a full frame to relock
    send_frame(PAT, 1);
    for (int i = 0; i < 5; i++) send_slot(PAT[11-i], SC, 0, 0, 0, 1'b1);
    chk("pre_rst_slot", int'(oSLOT), 5);
    chk("pre_rst_lock", int'(oLOCK), 1);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    chk("post_rst_lock", int'(oLOCK), 0);
    chk("post_rst_slot", int'(oSLOT), 0);
    chk("post_rst_frames", int'(oFRAMES), 0);
    chk("post_rst_err", int'(oERR), 0);
    for (int i = 5; i < 12; i++) send_slot(PAT[11-i], SC, 0, 0, 0, 1'b1);
    chk("no_lock_partial", int'(oLOCK), 0);
    send_frame(PAT, 1);
    chk("relock_after_rst", int'(oLOCK), 1);
    do_reset();

    repeat (20) @(posedge iCLK);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
